// File: rtl/framebuffer_scanout_if.sv
// framebuffer_scanout_if: framebuffer read port and video timing outputs
// of the scanout engine. master = scanout side, slave = memory/display side.
interface framebuffer_scanout_if;
   logic [31:0] anOutPixelAddr;
   logic        anOutPixelRead;
   logic [2:0]  aPixelData;
   logic        anOutHSync;
   logic        anOutVSync;
   logic        anOutDataEnable;
   logic [2:0]  anOutColor;

   modport master (
      output anOutPixelAddr, anOutPixelRead,
      output anOutHSync, anOutVSync, anOutDataEnable, anOutColor,
      input  aPixelData
   );

   modport slave (
      input  anOutPixelAddr, anOutPixelRead,
      input  anOutHSync, anOutVSync, anOutDataEnable, anOutColor,
      output aPixelData
   );
endinterface

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: double-buffered raster scanout. Walks an x/y raster,
// reads one pixel per visible cycle from the front buffer, emits syncs,
// data enable and colour two cycles after each raster position, and swaps
// front/back buffers at the start of vertical blanking when the renderer
// reports a finished frame.
// Optional feature: define SCANOUT_TEST_PATTERN_EN to add the aTestPattern
// input, which replaces memory colour with x[7:5] and suppresses reads.
module framebuffer_scanout #(
   parameter int unsigned H_ACTIVE      = 320,
   parameter int unsigned H_FRONT       = 8,
   parameter int unsigned H_SYNC        = 32,
   parameter int unsigned H_BACK        = 40,
   parameter int unsigned V_ACTIVE      = 240,
   parameter int unsigned V_FRONT       = 3,
   parameter int unsigned V_SYNC        = 4,
   parameter int unsigned V_BACK        = 15,
   parameter logic [31:0] BUFFER_STRIDE = 32'd76800
) (
   input  logic aClock,
   input  logic aReset,
   input  logic anEnable,
   input  logic aFrameDone,
`ifdef SCANOUT_TEST_PATTERN_EN
   input  logic aTestPattern,
`endif
   output logic anOutFrameFlipped,
   output logic anOutBackBuffer,
   framebuffer_scanout_if.master aBus
);

   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned XW       = $clog2(H_TOTAL + 1);
   localparam int unsigned YW       = $clog2(V_TOTAL + 1);
   localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   typedef enum logic {IDLE, SCAN} scanState_e;

   scanState_e    state, stateNext;
   logic [XW-1:0] x, xNext;
   logic [YW-1:0] y, yNext;
   logic          flipNow;
   logic          front, frontNext;
   logic          readNext;

   logic          pixelRead;
   logic [31:0]   pixelAddr;
   logic          backBuffer;
   logic          frameFlipped;

   logic          s1Visible, s1HSync, s1VSync;
   logic          hSync, vSync, dataEnable;
   logic [2:0]    color;
`ifdef SCANOUT_TEST_PATTERN_EN
   logic          s1Pattern;
   logic [2:0]    s1PatColor;
`endif

   // The back buffer register is the single copy of the buffer index
   assign front     = ~backBuffer;
   assign frontNext = front ^ flipNow;

   // Next raster position, IDLE/SCAN transition and flip decision
   always_comb begin
      stateNext = state;
      xNext     = x;
      yNext     = y;
      flipNow   = 1'b0;
      case (state)
         IDLE: begin
            if (anEnable) stateNext = SCAN;
         end
         SCAN: begin
            flipNow = (x == '0) && (y == YW'(V_ACTIVE)) && aFrameDone;
            if (x == XW'(H_TOTAL - 1)) begin
               xNext = '0;
               if (y == YW'(V_TOTAL - 1)) begin
                  yNext = '0;
                  if (!anEnable) stateNext = IDLE;
               end else begin
                  yNext = y + YW'(1);
               end
            end else begin
               xNext = x + XW'(1);
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Read request for the position the counters move to next
   always_comb begin
      readNext = (stateNext == SCAN) && (xNext < XW'(H_ACTIVE)) && (yNext < YW'(V_ACTIVE));
`ifdef SCANOUT_TEST_PATTERN_EN
      if (aTestPattern) readNext = 1'b0;
`endif
   end

   // FSM state and raster counters
   always_ff @(posedge aClock or negedge aReset) begin
      if (!aReset) begin
         state <= IDLE;
         x     <= '0;
         y     <= '0;
      end else begin
         state <= stateNext;
         x     <= xNext;
         y     <= yNext;
      end
   end

   // Read strobe aligned with the raster position; address holds in blanking
   always_ff @(posedge aClock or negedge aReset) begin
      if (!aReset) begin
         pixelRead <= 1'b0;
         pixelAddr <= '0;
      end else begin
         pixelRead <= readNext;
         if (readNext) begin
            pixelAddr <= 32'(xNext) + 32'(yNext) * 32'(H_ACTIVE)
                       + (frontNext ? BUFFER_STRIDE : 32'd0);
         end
      end
   end

   // Buffer swap and its one-cycle notification
   always_ff @(posedge aClock or negedge aReset) begin
      if (!aReset) begin
         backBuffer   <= 1'b1;
         frameFlipped <= 1'b0;
      end else begin
         backBuffer   <= backBuffer ^ flipNow;
         frameFlipped <= flipNow;
      end
   end

   // First video stage: timing decoded from the current raster position
   always_ff @(posedge aClock or negedge aReset) begin
      if (!aReset) begin
         s1Visible  <= 1'b0;
         s1HSync    <= 1'b1;
         s1VSync    <= 1'b1;
`ifdef SCANOUT_TEST_PATTERN_EN
         s1Pattern  <= 1'b0;
         s1PatColor <= '0;
`endif
      end else if (state == SCAN) begin
         s1Visible  <= (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
         s1HSync    <= !((x >= XW'(HS_START)) && (x < XW'(HS_END)));
         s1VSync    <= !((y >= YW'(VS_START)) && (y < YW'(VS_END)));
`ifdef SCANOUT_TEST_PATTERN_EN
         // A visible position without a read strobe was a pattern pixel
         s1Pattern  <= !pixelRead;
         s1PatColor <= 3'(x >> 5);
`endif
      end else begin
         s1Visible  <= 1'b0;
         s1HSync    <= 1'b1;
         s1VSync    <= 1'b1;
`ifdef SCANOUT_TEST_PATTERN_EN
         s1Pattern  <= 1'b0;
         s1PatColor <= '0;
`endif
      end
   end

   // Second video stage: outputs, colour taken from the returning read data
   always_ff @(posedge aClock or negedge aReset) begin
      if (!aReset) begin
         hSync      <= 1'b1;
         vSync      <= 1'b1;
         dataEnable <= 1'b0;
         color      <= '0;
      end else begin
         hSync      <= s1HSync;
         vSync      <= s1VSync;
         dataEnable <= s1Visible;
         if (!s1Visible) begin
            color <= '0;
`ifdef SCANOUT_TEST_PATTERN_EN
         end else if (s1Pattern) begin
            color <= s1PatColor;
`endif
         end else begin
            color <= aBus.aPixelData;
         end
      end
   end

   assign anOutFrameFlipped    = frameFlipped;
   assign anOutBackBuffer      = backBuffer;
   assign aBus.anOutPixelRead  = pixelRead;
   assign aBus.anOutPixelAddr  = pixelAddr;
   assign aBus.anOutHSync      = hSync;
   assign aBus.anOutVSync      = vSync;
   assign aBus.anOutDataEnable = dataEnable;
   assign aBus.anOutColor      = color;

endmodule

// File: doc/framebuffer_scanout.md
FRAMEBUFFER_SCANOUT -- requirements
Module: framebuffer_scanout

Interface
REQ-001 Parameter H_ACTIVE, default 320: visible pixels per line.
REQ-002 Parameter H_FRONT/H_SYNC/H_BACK, defaults 8/32/40: horizontal front porch, sync, back porch in clocks (H_TOTAL=400).
REQ-003 Parameter V_ACTIVE, default 240: visible lines per frame.
REQ-004 Parameter V_FRONT/V_SYNC/V_BACK, defaults 3/4/15: vertical porch/sync in lines (V_TOTAL=262).
REQ-005 Parameter BUFFER_STRIDE, default 32'd76800: word offset of buffer 1 from buffer 0.
REQ-006 aClock  input  1  single clock; one pixel per cycle.
REQ-007 aReset  input  1  asynchronous, active-low reset.
REQ-008 anEnable  input  1  scanout run request (level).
REQ-009 aFrameDone  input  1  renderer has finished the back buffer (level, held until flip).
REQ-010 anOutFrameFlipped  output  1  one-cycle pulse: buffers swapped.
REQ-011 anOutBackBuffer  output  1  index of buffer the renderer may write.
REQ-012 anOutPixelAddr  output  32  framebuffer read address.
REQ-013 anOutPixelRead  output  1  read strobe; data returned next cycle.
REQ-014 aPixelData  input  3  read data, valid exactly 1 cycle after strobe.
REQ-015 anOutHSync, anOutVSync  output  1 each  active-low syncs.
REQ-016 anOutDataEnable  output  1  high for visible pixels.
REQ-017 anOutColor  output  3  pixel colour, 0 when not visible.

Function
REQ-018 States: IDLE, SCAN; IDLE->SCAN when anEnable=1 (counters at 0,0); SCAN->IDLE only at end of last line (x=H_TOTAL-1, y=V_TOTAL-1) with anEnable=0; mid-frame deassertion completes the frame.
REQ-019 Counters x (0..H_TOTAL-1), y (0..V_TOTAL-1) advance every cycle in SCAN; x wraps to 0 and increments y; y wraps to 0 after V_TOTAL-1; both held at 0 in IDLE.
REQ-020 Visible = x<H_ACTIVE and y<V_ACTIVE; in visible cycles anOutPixelRead=1, anOutPixelAddr = x + y*H_ACTIVE + (front?BUFFER_STRIDE:0), computed 32-bit; else anOutPixelRead=0, address held.
REQ-021 HSync low when H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC; VSync low when V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC.
REQ-022 Video outputs (syncs, data enable, colour) registered with fixed 2-cycle latency from counter position; anOutColor = aPixelData captured when enable set, else 0.
REQ-023 Front buffer index front; anOutBackBuffer = ~front at all times.
REQ-024 Flip point: cycle with x=0, y=V_ACTIVE in SCAN; if aFrameDone=1 there, front toggles and anOutFrameFlipped pulses high for that following cycle only; if 0, no flip, frame repeats.
REQ-025 aFrameDone rising after flip point waits for next frame's flip point; at most one flip per frame.
REQ-026 In IDLE: no reads, syncs high, enable/colour 0, no flips.

Reset
REQ-027 aReset low asynchronously forces: state IDLE, x=y=0, front=0, anOutBackBuffer=1, anOutPixelRead=0, anOutPixelAddr=0, anOutFrameFlipped=0, syncs=1, anOutDataEnable=0, anOutColor=0, pipeline cleared.
REQ-028 Reset mid-frame discards in-flight read data; first frame after release starts at x=y=0.

Configuration
REQ-029 SCANOUT_TEST_PATTERN_EN defined: adds input aTestPattern (1 bit); when 1, visible colour = x[7:5], anOutPixelRead stays 0, flips still occur; timing unchanged.
REQ-030 SCANOUT_TEST_PATTERN_EN undefined: no aTestPattern port; colour always from memory.

Verification
REQ-031 Reset release, anEnable=1, memory returns addr[2:0] -> pixel (5,0) colour 5 two cycles after x=5; first read address 0.
REQ-032 Full frame -> exactly 76800 read strobes, 240 VSync-free visible lines, HSync low at x=328..359, VSync low lines 243..246.
REQ-033 aFrameDone=1 at y=100 -> flip pulse one cycle after x=0,y=240; anOutBackBuffer 1->0; next frame first address 76800.
REQ-034 aFrameDone=0 through frame -> no pulse, addresses restart at 0.
REQ-035 anEnable dropped at y=50 -> frame completes to y=261, then IDLE; reads stop; aReset low at x=10,y=10 -> all outputs to reset values same cycle.
REQ-036 SCANOUT_TEST_PATTERN_EN, aTestPattern=1 -> x=64 yields colour 2, no read strobes.
